dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the Control_Unit datapath and the debug/program-loader port.
- Fixed-latency request/grant handshake on each side.
- Round-robin arbitration between the two requesters.
- A debug lock that excludes the CPU while memory is being loaded.
- Sits between Control_Unit/register file and the data RAM; drives D_ADDR/D_WR in place of the control unit.

Parameters:
RD_LAT, 1, data RAM read latency in cycles (legal range 1..4)
AW, 8, data address width
DW, 16, data word width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
CPU_REQ  in  1  CPU access request, held until CPU_GNT
CPU_WR  in  1  1=write, 0=read
CPU_ADDR  in  AW  CPU address
CPU_WDATA  in  DW  CPU write data
CPU_GNT  out  1  one-cycle pulse: CPU access issued this cycle
CPU_VALID  out  1  one-cycle pulse: CPU read data on CPU_RDATA
CPU_RDATA  out  DW  read data
DBG_REQ, DBG_WR, DBG_ADDR, DBG_WDATA, DBG_GNT, DBG_VALID, DBG_RDATA  same as the CPU set, for the debug port
DBG_LOCK  in  1  1 = CPU requests are never granted
D_ADDR  out  AW  RAM address
D_WR  out  1  RAM write enable
D_WDATA  out  DW  RAM write data
D_RDATA  in  DW  RAM read data, valid RD_LAT cycles after address

Behaviour:
- States:
  - ARB: free. Grant is possible in this cycle.
  - RD_WAIT: read outstanding. Latency counter lat_cnt runs; owner register rd_owner records the requester.
- Registered state: state, lat_cnt (2 bits), rd_owner, last_gnt.
- Reset (Reset=0, asynchronous): state=ARB, lat_cnt=0, rd_owner=CPU, last_gnt=DBG, so the CPU wins the first tie.
  - All outputs are 0 while in reset and in ARB with no requests: GNT, VALID, D_WR, D_ADDR, D_WDATA, RDATA.
- Eligibility: cpu_el = CPU_REQ & ~DBG_LOCK; dbg_el = DBG_REQ.
- Grant rules (combinational, only in ARB, or in the RD_WAIT cycle where lat_cnt reaches RD_LAT):
  - Exactly one requester eligible: grant it.
  - Both eligible: grant the one not equal to last_gnt. last_gnt updates on every grant.
  - GNT is asserted for exactly one cycle, the issue cycle.
  - In the issue cycle, D_ADDR/D_WR/D_WDATA come combinationally from the granted requester.
  - D_WR=0 and D_WDATA=0 on any cycle without a write grant. D_ADDR=0 when there is no grant.
- Write: completes in the issue cycle; no VALID. Next cycle stays ARB, so back-to-back writes run at 1 per cycle.
- Read:
  - Issue cycle t: D_WR=0. Next state RD_WAIT, lat_cnt=1, rd_owner=granted requester.
  - Cycle t+RD_LAT: owner's VALID=1 and owner's RDATA=D_RDATA (pass-through). Non-owner RDATA stays 0.
  - In that same cycle, arbitration is live, so a new grant may issue (read-to-next-access gap = RD_LAT cycles).
  - Returns to ARB if there is no grant or a write grant; RD_WAIT if a new read is granted.
- Requester rule: REQ held with stable WR/ADDR/WDATA until GNT. REQ may drop in the GNT cycle or stay high for the next access.
- DBG_LOCK:
  - Sampled combinationally each arbitration cycle.
  - Asserting it during an outstanding CPU read does not cancel that read; CPU_VALID is still delivered.
  - While locked, CPU_REQ waits with no error.
- Reset mid-read: the outstanding VALID is dropped, never asserted after reset release.
- Each requester has at most one outstanding read.
- RD_LAT outside 1..4: elaboration error ($error in generate).

Decomposition:
- Package dmem_arb_pkg: arb_state_t {ARB, RD_WAIT}; requester_t {REQ_CPU, REQ_DBG}; constant MAX_RD_LAT=4.
- Sub-module dmem_rr_picker: inputs cpu_el, dbg_el, last_gnt; outputs gnt_valid, gnt_who. Purely combinational.
- The top holds the FSM, counter and muxes.

Test Plan:
1. Reset=0 for 5 cycles, then 1 with no requests -> all outputs 0. First simultaneous CPU/DBG read to addr 8'h10/8'h20 -> CPU_GNT first, D_ADDR=8'h10.
2. CPU write addr 8'h05, data 16'hBEEF, then CPU read 8'h05 with RD_LAT=1 -> D_WR=1 one cycle. Read GNT next cycle; CPU_VALID one cycle later with CPU_RDATA=16'hBEEF; DBG_VALID=0 throughout.
3. Both requesters hold read REQ continuously for 6 grants -> grants alternate CPU,DBG,CPU,DBG,CPU,DBG. Each VALID goes to the correct owner.
4. DBG_LOCK=1 with CPU_REQ and DBG_REQ high -> only DBG granted; CPU_GNT=0. Lock dropped -> CPU granted on the next arbitration cycle.
5. RD_LAT=3, CPU read issued at cycle t, Reset pulsed low at t+1 -> CPU_VALID never asserted; state=ARB after release; next CPU read works normally.
6. RD_LAT=2, DBG read issued at t with CPU write pending -> CPU_GNT=0 at t+1. CPU_GNT=1 with D_WR=1 at t+2, the same cycle as DBG_VALID=1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and limits for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic {ARB = 1'b0, RD_WAIT = 1'b1} arb_state_t;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} requester_t;
  localparam int MAX_RD_LAT = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, debug and RAM-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 16);
  logic          CPU_REQ, CPU_WR, CPU_GNT, CPU_VALID;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA, CPU_RDATA;
  logic          DBG_REQ, DBG_WR, DBG_GNT, DBG_VALID, DBG_LOCK;
  logic [AW-1:0] DBG_ADDR;
  logic [DW-1:0] DBG_WDATA, DBG_RDATA;
  logic [AW-1:0] D_ADDR;
  logic          D_WR;
  logic [DW-1:0] D_WDATA, D_RDATA;

  modport master (
    output CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA,
    output DBG_REQ, DBG_WR, DBG_ADDR, DBG_WDATA, DBG_LOCK,
    input  CPU_GNT, CPU_VALID, CPU_RDATA, DBG_GNT, DBG_VALID, DBG_RDATA,
    input  D_ADDR, D_WR, D_WDATA,
    output D_RDATA
  );

  modport slave (
    input  CPU_REQ, CPU_WR, CPU_ADDR, CPU_WDATA,
    input  DBG_REQ, DBG_WR, DBG_ADDR, DBG_WDATA, DBG_LOCK,
    output CPU_GNT, CPU_VALID, CPU_RDATA, DBG_GNT, DBG_VALID, DBG_RDATA,
    output D_ADDR, D_WR, D_WDATA,
    input  D_RDATA
  );
endinterface

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes.
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic       cpu_el,
  input  logic       dbg_el,
  input  requester_t last_gnt,
  output logic       gnt_valid,
  output requester_t gnt_who
);
  always_comb begin
    gnt_valid = cpu_el | dbg_el;
    gnt_who   = REQ_CPU;
    if (cpu_el && dbg_el)
      gnt_who = (last_gnt == REQ_CPU) ? REQ_DBG : REQ_CPU;
    else if (dbg_el)
      gnt_who = REQ_DBG;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM shared between CPU and debug loader; fixed read latency,
// round-robin grants, and a debug lock that fences the CPU out.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 8,
  parameter int DW     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("dmem_arbiter: RD_LAT must be in 1..%0d", MAX_RD_LAT);
  end

  // 2-bit counter wraps, so RD_LAT=4 completes when lat_cnt returns to 0.
  localparam logic [1:0] LAT_MATCH = 2'(RD_LAT);

  arb_state_t state;
  logic [1:0] lat_cnt;
  requester_t rd_owner, last_gnt;

  logic       cpu_el, dbg_el, pick_valid, rd_done, arb_live, gnt;
  requester_t pick_who;
  logic       g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  assign cpu_el   = bus.CPU_REQ & ~bus.DBG_LOCK;
  assign dbg_el   = bus.DBG_REQ;
  assign rd_done  = (state == RD_WAIT) && (lat_cnt == LAT_MATCH);
  assign arb_live = (state == ARB) || rd_done;
  assign gnt      = arb_live & pick_valid;

  dmem_rr_picker u_picker (
    .cpu_el   (cpu_el),
    .dbg_el   (dbg_el),
    .last_gnt (last_gnt),
    .gnt_valid(pick_valid),
    .gnt_who  (pick_who)
  );

  always_comb begin
    g_wr    = (pick_who == REQ_DBG) ? bus.DBG_WR    : bus.CPU_WR;
    g_addr  = (pick_who == REQ_DBG) ? bus.DBG_ADDR  : bus.CPU_ADDR;
    g_wdata = (pick_who == REQ_DBG) ? bus.DBG_WDATA : bus.CPU_WDATA;

    bus.CPU_GNT   = gnt && (pick_who == REQ_CPU);
    bus.DBG_GNT   = gnt && (pick_who == REQ_DBG);
    bus.D_ADDR    = gnt ? g_addr : '0;
    bus.D_WR      = gnt & g_wr;
    bus.D_WDATA   = (gnt & g_wr) ? g_wdata : '0;

    // Read data is a gated pass-through; the non-owner always sees zero.
    bus.CPU_VALID = rd_done && (rd_owner == REQ_CPU);
    bus.DBG_VALID = rd_done && (rd_owner == REQ_DBG);
    bus.CPU_RDATA = bus.CPU_VALID ? bus.D_RDATA : '0;
    bus.DBG_RDATA = bus.DBG_VALID ? bus.D_RDATA : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      lat_cnt  <= 2'd0;
      rd_owner <= REQ_CPU;
      last_gnt <= REQ_DBG;
    end else begin
      if (gnt) last_gnt <= pick_who;
      if (gnt && !g_wr) begin
        state    <= RD_WAIT;
        lat_cnt  <= 2'd1;
        rd_owner <= pick_who;
      end else if (arb_live) begin
        state    <= ARB;
        lat_cnt  <= 2'd0;
      end else begin
        lat_cnt  <= lat_cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 1,3,2) with RAM models and a read-return scoreboard.
module tb_dmem_arbiter;
  typedef struct packed {
    logic        dbg;
    logic [15:0] data;
  } sb_t;

  localparam int NI = 3;
  localparam int LATS [NI] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req [NI], cpu_wr [NI], dbg_req [NI], dbg_wr [NI], dbg_lock [NI];
  logic [7:0]  cpu_addr [NI], dbg_addr [NI];
  logic [15:0] cpu_wdata [NI], dbg_wdata [NI];
  logic        cpu_gnt [NI], cpu_valid [NI], dbg_gnt [NI], dbg_valid [NI], d_wr [NI];
  logic [15:0] cpu_rdata [NI], dbg_rdata [NI], d_wdata [NI];
  logic [7:0]  d_addr [NI];

  int  vecs = 0;
  int  errs = 0;
  sb_t sb [NI][$];

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_arbiter_if #(.AW(8), .DW(16)) bus ();
    logic [15:0] mem  [256];
    logic [15:0] pipe [4];

    dmem_arbiter #(.RD_LAT(LATS[g]), .AW(8), .DW(16)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );

    assign bus.CPU_REQ   = cpu_req[g];
    assign bus.CPU_WR    = cpu_wr[g];
    assign bus.CPU_ADDR  = cpu_addr[g];
    assign bus.CPU_WDATA = cpu_wdata[g];
    assign bus.DBG_REQ   = dbg_req[g];
    assign bus.DBG_WR    = dbg_wr[g];
    assign bus.DBG_ADDR  = dbg_addr[g];
    assign bus.DBG_WDATA = dbg_wdata[g];
    assign bus.DBG_LOCK  = dbg_lock[g];
    assign bus.D_RDATA   = pipe[LATS[g]-1];
    assign cpu_gnt[g]    = bus.CPU_GNT;
    assign cpu_valid[g]  = bus.CPU_VALID;
    assign cpu_rdata[g]  = bus.CPU_RDATA;
    assign dbg_gnt[g]    = bus.DBG_GNT;
    assign dbg_valid[g]  = bus.DBG_VALID;
    assign dbg_rdata[g]  = bus.DBG_RDATA;
    assign d_addr[g]     = bus.D_ADDR;
    assign d_wr[g]       = bus.D_WR;
    assign d_wdata[g]    = bus.D_WDATA;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
      for (int i = 0; i < 4; i++) pipe[i] = 16'h0;
    end

    always @(posedge clk) begin
      if (bus.D_WR) mem[bus.D_ADDR] <= bus.D_WDATA;
      pipe[0] <= mem[bus.D_ADDR];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Read-return checker: every VALID must match the oldest expected return.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      if (cpu_valid[k] || dbg_valid[k]) begin
        vecs++;
        if (sb[k].size() == 0 || (cpu_valid[k] && dbg_valid[k])) begin
          errs++;
          $display("FAIL sb_unexpected k=%0d cpu_valid=%0b dbg_valid=%0b queued=%0d", k, cpu_valid[k], dbg_valid[k], sb[k].size());
        end else begin
          sb_t e;
          logic [15:0] got, other;
          e = sb[k].pop_front();
          got   = e.dbg ? dbg_rdata[k] : cpu_rdata[k];
          other = e.dbg ? cpu_rdata[k] : dbg_rdata[k];
          if ({dbg_valid[k], got, other} !== {e.dbg, e.data, 16'h0}) begin
            errs++;
            $display("FAIL sb_return k=%0d got owner_dbg=%0b data=%h other=%h exp owner_dbg=%0b data=%h other=0000",
                     k, dbg_valid[k], got, other, e.dbg, e.data);
          end
        end
      end else begin
        vecs++;
        if ({cpu_rdata[k], dbg_rdata[k]} !== 32'h0) begin
          errs++;
          $display("FAIL rdata_idle k=%0d got cpu=%h dbg=%h exp 0", k, cpu_rdata[k], dbg_rdata[k]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string nm, input int k, input logic ec, input logic ed,
                         input logic [7:0] ea, input logic ew, input logic [15:0] ewd);
    vecs++;
    if ({cpu_gnt[k], dbg_gnt[k], d_addr[k], d_wr[k], d_wdata[k]} !== {ec, ed, ea, ew, ewd}) begin
      errs++;
      $display("FAIL %s k=%0d got cgnt=%0b dgnt=%0b addr=%h wr=%0b wd=%h exp cgnt=%0b dgnt=%0b addr=%h wr=%0b wd=%h",
               nm, k, cpu_gnt[k], dbg_gnt[k], d_addr[k], d_wr[k], d_wdata[k], ec, ed, ea, ew, ewd);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      for (int k = 0; k < NI; k++) begin
        vecs++;
        if ({cpu_gnt[k], dbg_gnt[k], cpu_valid[k], dbg_valid[k], d_wr[k], d_addr[k], d_wdata[k]} !== '0) begin
          errs++;
          $display("FAIL reset_outs k=%0d got gnt=%0b%0b valid=%0b%0b wr=%0b addr=%h wd=%h exp all 0",
                   k, cpu_gnt[k], dbg_gnt[k], cpu_valid[k], dbg_valid[k], d_wr[k], d_addr[k], d_wdata[k]);
        end
      end
    end
    step(); rst_n = 1'b1; #1;
    for (int k = 0; k < NI; k++) chk_gnt("idle_outs", k, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
    step();
    cpu_req[0] = 1'b1; cpu_addr[0] = 8'h10;
    dbg_req[0] = 1'b1; dbg_addr[0] = 8'h20;
    sb[0].push_back('{1'b0, pat(8'h10)});
    sb[0].push_back('{1'b1, pat(8'h20)});
    #1 chk_gnt("first_tie_cpu", 0, 1'b1, 1'b0, 8'h10, 1'b0, 16'h0);
    step(); cpu_req[0] = 1'b0;
    #1 chk_gnt("tie_then_dbg", 0, 1'b0, 1'b1, 8'h20, 1'b0, 16'h0);
    step(); dbg_req[0] = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_alternate();
    logic [7:0] ca, da;
    logic       ed;
    ca = 8'h30; da = 8'h40;
    for (int i = 0; i < 6; i++) begin
      step();
      cpu_req[0] = 1'b1; cpu_addr[0] = ca;
      dbg_req[0] = 1'b1; dbg_addr[0] = da;
      ed = (i % 2) == 1;
      sb[0].push_back('{ed, pat(ed ? da : ca)});
      #1 chk_gnt("alternate", 0, ~ed, ed, ed ? da : ca, 1'b0, 16'h0);
      if (ed) da++; else ca++;
    end
    step(); cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    #1 chk_gnt("alternate_stop", 0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
    repeat (2) step();
  endtask

  task automatic test_write_read();
    step();
    cpu_req[0] = 1'b1; cpu_wr[0] = 1'b1; cpu_addr[0] = 8'h05; cpu_wdata[0] = 16'hBEEF;
    #1 chk_gnt("cpu_write", 0, 1'b1, 1'b0, 8'h05, 1'b1, 16'hBEEF);
    step(); cpu_wr[0] = 1'b0;
    sb[0].push_back('{1'b0, 16'hBEEF});
    #1 chk_gnt("read_after_write", 0, 1'b1, 1'b0, 8'h05, 1'b0, 16'h0);
    step(); cpu_req[0] = 1'b0; #1;
    vecs++;
    if ({cpu_valid[0], dbg_valid[0], cpu_rdata[0], d_wr[0]} !== {2'b10, 16'hBEEF, 1'b0}) begin
      errs++;
      $display("FAIL wr_rd_valid got cv=%0b dv=%0b rd=%h wr=%0b exp cv=1 dv=0 rd=beef wr=0",
               cpu_valid[0], dbg_valid[0], cpu_rdata[0], d_wr[0]);
    end
    step(); #1;
    vecs++;
    if ({cpu_valid[0], dbg_valid[0]} !== 2'b00) begin
      errs++;
      $display("FAIL wr_rd_single got cv=%0b dv=%0b exp 0 0", cpu_valid[0], dbg_valid[0]);
    end
  endtask

  task automatic test_lock();
    step();
    dbg_lock[0] = 1'b1;
    cpu_req[0] = 1'b1; cpu_addr[0] = 8'h50;
    dbg_req[0] = 1'b1; dbg_addr[0] = 8'h60;
    sb[0].push_back('{1'b1, pat(8'h60)});
    #1 chk_gnt("lock_dbg_only", 0, 1'b0, 1'b1, 8'h60, 1'b0, 16'h0);
    for (int i = 1; i < 3; i++) begin
      step(); dbg_addr[0] = 8'(8'h60 + i);
      sb[0].push_back('{1'b1, pat(8'(8'h60 + i))});
      #1 chk_gnt("lock_dbg_only", 0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 16'h0);
    end
    step(); dbg_req[0] = 1'b0; dbg_lock[0] = 1'b0;
    sb[0].push_back('{1'b0, pat(8'h50)});
    #1 chk_gnt("unlock_cpu", 0, 1'b1, 1'b0, 8'h50, 1'b0, 16'h0);
    step(); cpu_addr[0] = 8'h51;
    sb[0].push_back('{1'b0, pat(8'h51)});
    #1 chk_gnt("cpu_next", 0, 1'b1, 1'b0, 8'h51, 1'b0, 16'h0);
    step(); cpu_req[0] = 1'b0; dbg_lock[0] = 1'b1; #1;
    vecs++;
    if ({cpu_valid[0], cpu_rdata[0]} !== {1'b1, pat(8'h51)}) begin
      errs++;
      $display("FAIL lock_keeps_read got cv=%0b rd=%h exp cv=1 rd=%h", cpu_valid[0], cpu_rdata[0], pat(8'h51));
    end
    step(); dbg_lock[0] = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    step();
    cpu_req[1] = 1'b1; cpu_addr[1] = 8'h70;
    #1 chk_gnt("lat3_issue", 1, 1'b1, 1'b0, 8'h70, 1'b0, 16'h0);
    step(); cpu_req[1] = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vecs++;
      if (cpu_valid[1] !== 1'b0) begin
        errs++;
        $display("FAIL valid_after_reset cyc=%0d got %0b exp 0", c, cpu_valid[1]);
      end
      step();
    end
    cpu_req[1] = 1'b1; cpu_addr[1] = 8'h71;
    sb[1].push_back('{1'b0, pat(8'h71)});
    #1 chk_gnt("post_reset_issue", 1, 1'b1, 1'b0, 8'h71, 1'b0, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      step(); cpu_req[1] = 1'b0; #1;
      vecs++;
      if (cpu_valid[1] !== (c == 3)) begin
        errs++;
        $display("FAIL lat3_timing cyc=t+%0d got cv=%0b exp %0b", c, cpu_valid[1], c == 3);
      end
    end
  endtask

  task automatic test_rd_to_write();
    step();
    dbg_req[2] = 1'b1; dbg_addr[2] = 8'h80;
    sb[2].push_back('{1'b1, pat(8'h80)});
    #1 chk_gnt("lat2_dbg_issue", 2, 1'b0, 1'b1, 8'h80, 1'b0, 16'h0);
    step(); dbg_req[2] = 1'b0;
    cpu_req[2] = 1'b1; cpu_wr[2] = 1'b1; cpu_addr[2] = 8'h81; cpu_wdata[2] = 16'h1234;
    #1 chk_gnt("lat2_blocked", 2, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0);
    step(); #1;
    chk_gnt("lat2_write_with_valid", 2, 1'b1, 1'b0, 8'h81, 1'b1, 16'h1234);
    vecs++;
    if ({dbg_valid[2], dbg_rdata[2]} !== {1'b1, pat(8'h80)}) begin
      errs++;
      $display("FAIL lat2_dbg_valid got dv=%0b rd=%h exp dv=1 rd=%h", dbg_valid[2], dbg_rdata[2], pat(8'h80));
    end
    step(); cpu_wr[2] = 1'b0;
    sb[2].push_back('{1'b0, 16'h1234});
    #1 chk_gnt("lat2_readback_issue", 2, 1'b1, 1'b0, 8'h81, 1'b0, 16'h0);
    step(); cpu_req[2] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      cpu_req[k] = 1'b0; cpu_wr[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dbg_req[k] = 1'b0; dbg_wr[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
      dbg_lock[k] = 1'b0;
    end
    test_reset();
    test_alternate();
    test_write_read();
    test_lock();
    test_reset_mid_read();
    test_rd_to_write();
    repeat (4) step();
    for (int k = 0; k < NI; k++) begin
      vecs++;
      if (sb[k].size() != 0) begin
        errs++;
        $display("FAIL sb_drain k=%0d got %0d pending exp 0", k, sb[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
